// File: rtl/txcea_mc.sv
`default_nettype none
// ============================================================================
// Module   : txcea_mc
// Brief    : Multi-channel sensor frame transmitter. Fetches one or all
//            channel words from storage and serialises a framed response
//            (ID, frame count, data, 16-bit checksum) byte by byte.
// Revision : 1.0 - initial release
// ============================================================================
module txcea_mc #(
    parameter int          NUM_CH  = 4,
    parameter int          DATA_W  = 32,
    parameter logic [15:0] DEV_ID  = 16'hA55A,
    parameter int          TIMEOUT = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        cmd,
    input  logic              cmd_flag,
    output logic [7:0]        req_cmd,
    output logic              req_cmd_flag,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_data_flag,
    output logic [7:0]        bus_data,
    output logic              bus_data_flag,
    input  logic              bus_send_finish,
    output logic              busy,
    output logic              timeout_err
);

    localparam int             c_db       = DATA_W / 8;
    localparam int             c_idx_w    = $clog2(c_db + 5);
    localparam int             c_tc_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_len_hdr  = c_idx_w'(4);
    localparam logic [c_idx_w-1:0] c_len_data = c_idx_w'(c_db);
    localparam logic [c_idx_w-1:0] c_len_csum = c_idx_w'(2);
    localparam logic [c_tc_w-1:0]  c_tc_one   = c_tc_w'(1);
    localparam logic [c_tc_w-1:0]  c_tc_max   = c_tc_w'(TIMEOUT - 1);
    localparam logic [7:0]     c_num_ch   = 8'(NUM_CH);
    localparam logic [6:0]     c_last_ch  = 7'(NUM_CH - 1);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_hdr  = 3'd1;
    localparam logic [2:0] c_st_req  = 3'd2;
    localparam logic [2:0] c_st_wait = 3'd3;
    localparam logic [2:0] c_st_data = 3'd4;
    localparam logic [2:0] c_st_csum = 3'd5;

    logic [2:0]         r_state;
    logic [c_idx_w-1:0] r_idx;
    logic               r_pend;
    logic [DATA_W-1:0]  r_word;
    logic [15:0]        r_csum;
    logic [15:0]        r_frame_cnt;
    logic [6:0]         r_ch;
    logic [6:0]         r_ch_end;
    logic [c_tc_w-1:0]  r_tcnt;

    logic               w_send;
    logic [c_idx_w-1:0] w_len;
    logic               w_fin;
    logic               w_last;
    logic               w_go;
    logic               w_done;
    logic [7:0]         w_byte;
    logic               w_cmd_ok;

    // r_idx counts bytes already strobed in the current state; a byte is
    // issued either on state entry (nothing pending) or on the finish of
    // the previous byte when more remain.
    always_comb begin
        w_send = (r_state == c_st_hdr) || (r_state == c_st_data) || (r_state == c_st_csum);
        w_len  = '0;
        w_byte = 8'h00;
        case (r_state)
            c_st_hdr: begin
                w_len = c_len_hdr;
                case (r_idx[1:0])
                    2'd0:    w_byte = DEV_ID[15:8];
                    2'd1:    w_byte = DEV_ID[7:0];
                    2'd2:    w_byte = r_frame_cnt[15:8];
                    default: w_byte = r_frame_cnt[7:0];
                endcase
            end
            c_st_data: begin
                w_len  = c_len_data;
                w_byte = r_word[DATA_W-1 -: 8];
            end
            c_st_csum: begin
                w_len  = c_len_csum;
                w_byte = (r_idx == '0) ? r_csum[15:8] : r_csum[7:0];
            end
            default: ;
        endcase
        w_fin    = r_pend && bus_send_finish;
        w_last   = (r_idx == w_len);
        w_go     = w_send && (!r_pend || (w_fin && !w_last));
        w_done   = w_send && w_fin && w_last;
        w_cmd_ok = cmd_flag && ((!cmd[7] && (cmd < c_num_ch)) || (cmd == 8'h80));
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state       <= c_st_idle;
            r_idx         <= '0;
            r_pend        <= 1'b0;
            r_word        <= '0;
            r_csum        <= '0;
            r_frame_cnt   <= '0;
            r_ch          <= '0;
            r_ch_end      <= '0;
            r_tcnt        <= '0;
            req_cmd       <= '0;
            req_cmd_flag  <= 1'b0;
            bus_data      <= '0;
            bus_data_flag <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            bus_data_flag <= 1'b0;
            req_cmd_flag  <= 1'b0;
            timeout_err   <= 1'b0;

            if (w_go) begin
                bus_data      <= w_byte;
                bus_data_flag <= 1'b1;
                r_pend        <= 1'b1;
                r_idx         <= r_idx + c_idx_one;
                if (r_state != c_st_csum)
                    r_csum <= r_csum + {8'h00, w_byte};
                if (r_state == c_st_data)
                    r_word <= r_word << 8;
            end else if (w_fin) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_cmd_ok) begin
                        r_state <= c_st_hdr;
                        busy    <= 1'b1;
                        r_idx   <= '0;
                        r_pend  <= 1'b0;
                        r_csum  <= '0;
                        if (cmd[7]) begin
                            r_ch     <= '0;
                            r_ch_end <= c_last_ch;
                        end else begin
                            r_ch     <= cmd[6:0];
                            r_ch_end <= cmd[6:0];
                        end
                    end
                end
                c_st_hdr: begin
                    if (w_done) begin
                        r_state <= c_st_req;
                        r_idx   <= '0;
                    end
                end
                c_st_req: begin
                    req_cmd      <= {1'b0, r_ch};
                    req_cmd_flag <= 1'b1;
                    r_tcnt       <= '0;
                    r_state      <= c_st_wait;
                end
                c_st_wait: begin
                    // Real data takes priority over a coincident timeout.
                    if (req_data_flag) begin
                        r_word  <= req_data;
                        r_state <= c_st_data;
                    end else if (r_tcnt == c_tc_max) begin
                        r_word      <= '1;
                        timeout_err <= 1'b1;
                        r_state     <= c_st_data;
                    end else begin
                        r_tcnt <= r_tcnt + c_tc_one;
                    end
                end
                c_st_data: begin
                    if (w_done) begin
                        r_idx <= '0;
                        if (r_ch == r_ch_end) begin
                            r_state <= c_st_csum;
                        end else begin
                            r_ch    <= r_ch + 7'd1;
                            r_state <= c_st_req;
                        end
                    end
                end
                c_st_csum: begin
                    if (w_done) begin
                        r_state     <= c_st_idle;
                        r_idx       <= '0;
                        busy        <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_txcea_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_txcea_mc
// Brief    : Scoreboard bench for txcea_mc with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_txcea_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd = '0;
    logic        cmd_flag = 1'b0;
    logic [7:0]  req_cmd;
    logic        req_cmd_flag;
    logic [31:0] req_data = '0;
    logic        req_data_flag = 1'b0;
    logic [7:0]  bus_data;
    logic        bus_data_flag;
    logic        bus_send_finish = 1'b0;
    logic        busy;
    logic        timeout_err;

    txcea_mc #(.NUM_CH(4), .DATA_W(32), .DEV_ID(16'hA55A), .TIMEOUT(16)) dut (
        .sys_clk        (clk),
        .sys_rst        (rst_n),
        .cmd            (cmd),
        .cmd_flag       (cmd_flag),
        .req_cmd        (req_cmd),
        .req_cmd_flag   (req_cmd_flag),
        .req_data       (req_data),
        .req_data_flag  (req_data_flag),
        .bus_data       (bus_data),
        .bus_data_flag  (bus_data_flag),
        .bus_send_finish(bus_send_finish),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       tight;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  rq[$];
    int          exp_to = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          fin_cyc = 0;
    int          req_cyc = 0;
    int          fin_delay = 1;
    bit          withhold = 1'b0;
    bit          mon_pend = 1'b0;
    logic [7:0]  held = '0;
    logic [15:0] sb_sum = '0;
    logic [31:0] chdata [4];
    logic [7:0]  rsp_ch;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every DUT strobe.
    always @(negedge clk) begin
        exp_t e;
        if (mon_pend) begin
            check("hold", {24'h0, bus_data}, {24'h0, held});
            if (bus_send_finish) begin
                mon_pend = 1'b0;
                fin_cyc  = cyc;
            end
        end
        if (bus_data_flag) begin
            if (mon_pend) begin
                check("extra_strobe", 32'd1, 32'd0);
            end else if (q.size() == 0) begin
                check("unexpected_byte", {24'h0, bus_data}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("byte", {24'h0, bus_data}, {24'h0, e.b});
                if (e.tight)
                    check("strobe_latency", cyc - fin_cyc, 32'd1);
            end
            mon_pend = 1'b1;
            held     = bus_data;
        end
        if (req_cmd_flag) begin
            req_cyc = cyc;
            if (rq.size() == 0)
                check("unexpected_req", {24'h0, req_cmd}, 32'hFFFF_FFFF);
            else
                check("req_cmd", {24'h0, req_cmd}, {24'h0, rq.pop_front()});
        end
        if (timeout_err) begin
            if (exp_to == 0) begin
                check("unexpected_timeout", 32'd1, 32'd0);
            end else begin
                check("timeout_delay", cyc - req_cyc, 32'd16);
                exp_to--;
            end
        end
    end

    // Bus TX model: acknowledges each byte after fin_delay cycles.
    always begin
        @(negedge clk);
        if (bus_data_flag) begin
            repeat (fin_delay) @(posedge clk);
            #1 bus_send_finish = 1'b1;
            @(posedge clk);
            #1 bus_send_finish = 1'b0;
        end
    end

    // Storage model: answers two cycles after a request unless withheld.
    always begin
        @(negedge clk);
        if (req_cmd_flag && !withhold) begin
            rsp_ch = req_cmd;
            repeat (2) @(posedge clk);
            #1 req_data = chdata[rsp_ch[1:0]];
            req_data_flag = 1'b1;
            @(posedge clk);
            #1 req_data_flag = 1'b0;
        end
    end

    task automatic push_b(input logic [7:0] b, input logic t);
        exp_t e;
        e.b = b;
        e.tight = t;
        q.push_back(e);
        sb_sum = sb_sum + {8'h00, b};
    endtask

    task automatic push_frame(input logic [15:0] fc, input int lo, input int hi, input bit sub);
        logic [31:0] w;
        logic [15:0] cs;
        sb_sum = '0;
        push_b(8'hA5, 1'b0);
        push_b(8'h5A, 1'b1);
        push_b(fc[15:8], 1'b1);
        push_b(fc[7:0], 1'b1);
        for (int ch = lo; ch <= hi; ch++) begin
            rq.push_back(8'(ch));
            w = sub ? 32'hFFFF_FFFF : chdata[ch];
            for (int k = 0; k < 4; k++)
                push_b(w[31-8*k -: 8], k != 0);
        end
        cs = sb_sum;
        push_b(cs[15:8], 1'b0);
        push_b(cs[7:0], 1'b1);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic exp_busy);
        @(posedge clk);
        #1 cmd = c;
        cmd_flag = 1'b1;
        @(posedge clk);
        #1 cmd_flag = 1'b0;
        @(negedge clk);
        check("busy_after_cmd", {31'h0, busy}, {31'h0, exp_busy});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_in_budget", {31'h0, (n < 4000)}, 32'd1);
        check("queue_empty", q.size(), 32'd0);
        check("req_queue_empty", rq.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chdata[0] = 32'h0000_0001;
        chdata[1] = 32'h0000_000F;
        chdata[2] = 32'h0000_0003;
        chdata[3] = 32'h0000_0004;
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", {req_cmd, req_cmd_flag, bus_data, bus_data_flag, busy, timeout_err},
              32'h0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: single channel 1, hand-computed frame
        push_b(8'hA5, 1'b0); push_b(8'h5A, 1'b1); push_b(8'h00, 1'b1); push_b(8'h00, 1'b1);
        push_b(8'h00, 1'b0); push_b(8'h00, 1'b1); push_b(8'h00, 1'b1); push_b(8'h0F, 1'b1);
        push_b(8'h01, 1'b0); push_b(8'h0E, 1'b1);
        rq.push_back(8'h01);
        send_cmd(8'h01, 1'b1);
        wait_idle();

        // 2: all-channel mode
        chdata[1] = 32'h0000_0002;
        push_frame(16'h0001, 0, 3, 1'b0);
        send_cmd(8'h80, 1'b1);
        wait_idle();

        // 3: storage timeout with substitution
        withhold = 1'b1;
        exp_to   = 1;
        push_frame(16'h0002, 2, 2, 1'b1);
        send_cmd(8'h02, 1'b1);
        wait_idle();
        check("timeout_seen", exp_to, 32'd0);
        withhold = 1'b0;

        // 4: invalid commands are ignored
        send_cmd(8'h05, 1'b0);
        send_cmd(8'h81, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("busy_after_invalid", {31'h0, busy}, 32'd0);

        // 5: slow bus and a command issued mid-frame
        fin_delay = 50;
        push_frame(16'h0003, 3, 3, 1'b0);
        send_cmd(8'h03, 1'b1);
        repeat (120) @(posedge clk);
        send_cmd(8'h00, 1'b1);
        wait_idle();
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("busy_after_dropped_cmd", {31'h0, busy}, 32'd0);
        fin_delay = 1;

        // 6: reset in the middle of DATA, then a fresh frame
        push_frame(16'h0004, 1, 1, 1'b0);
        send_cmd(8'h01, 1'b1);
        begin
            int n = 0;
            while (q.size() > 5 && n < 500) begin
                @(posedge clk);
                n++;
            end
            check("reached_data", {31'h0, (n < 500)}, 32'd1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              {req_cmd, req_cmd_flag, bus_data, bus_data_flag, busy, timeout_err}, 32'h0);
        q.delete();
        rq.delete();
        mon_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        push_b(8'hA5, 1'b0); push_b(8'h5A, 1'b1); push_b(8'h00, 1'b1); push_b(8'h00, 1'b1);
        push_b(8'h00, 1'b0); push_b(8'h00, 1'b1); push_b(8'h00, 1'b1); push_b(8'h01, 1'b1);
        push_b(8'h01, 1'b0); push_b(8'h00, 1'b1);
        rq.push_back(8'h00);
        send_cmd(8'h00, 1'b1);
        wait_idle();

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
